// File: rtl/snake_score_bcd_pkg.sv
// Shared constants, converter state type and the BCD add-3 helper for the
// snake score display path.
package snake_score_pkg;

    localparam int SCORE_W_DEFAULT   = 7;
    localparam int MAX_SCORE_DEFAULT = 99;
    localparam int BCD_DIGITS        = 2;
    localparam int BCD_W             = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Double-dabble correction: every nibble of 5 or more gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end else begin
                res[4*d +: 4] = bcd[4*d +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/snake_score_bcd_if.sv
// Game-event inputs and BCD display outputs of the score block.
interface snake_score_bcd_if;
    import snake_score_pkg::*;

    logic             inc;
    logic             clr;
    logic             show_hi;
    logic [BCD_W-1:0] ans;
    logic             ans_valid;
    logic             busy;
    logic             sat;

    // Game logic / bench side
    modport master (
        output inc, clr, show_hi,
        input  ans, ans_valid, busy, sat
    );

    // Score block side
    modport slave (
        input  inc, clr, show_hi,
        output ans, ans_valid, busy, sat
    );

endinterface

// File: rtl/snake_score_bcd_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3). Starts a conversion
// whenever its input differs from the last value converted, and only
// updates the registered ans once the full result is ready.
module bin2bcd_seq
    import snake_score_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] bin,
    output logic [BCD_W-1:0]   ans,
    output logic               ans_valid,
    output logic               busy
);

    localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SCORE_W - 1);

    conv_state_t        state_r,    state_next_s;
    logic [SCORE_W-1:0] shift_r,    shift_next_s;
    logic [BCD_W-1:0]   bcd_r,      bcd_next_s;
    logic [CNT_W-1:0]   cnt_r,      cnt_next_s;
    logic [SCORE_W-1:0] last_bin_r, last_bin_next_s;
    logic [BCD_W-1:0]   ans_r,      ans_next_s;
    logic               valid_r,    valid_next_s;
    logic               busy_r,     busy_next_s;
    logic [BCD_W-1:0]   adj_s;

    // Next-state and datapath for the IDLE -> SHIFT x SCORE_W -> DONE sequence
    always_comb begin
        state_next_s    = state_r;
        shift_next_s    = shift_r;
        bcd_next_s      = bcd_r;
        cnt_next_s      = cnt_r;
        last_bin_next_s = last_bin_r;
        ans_next_s      = ans_r;
        valid_next_s    = 1'b0;
        adj_s           = bcd_add3(bcd_r);

        case (state_r)
            IDLE: begin
                if (bin != last_bin_r) begin
                    shift_next_s    = bin;
                    last_bin_next_s = bin;
                    bcd_next_s      = {BCD_W{1'b0}};
                    cnt_next_s      = {CNT_W{1'b0}};
                    state_next_s    = SHIFT;
                end else begin
                    state_next_s    = IDLE;
                end
            end
            SHIFT: begin
                {bcd_next_s, shift_next_s} = {adj_s, shift_r} << 1'b1;
                cnt_next_s = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_STEP) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                ans_next_s   = bcd_r;
                valid_next_s = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        busy_next_s = (state_next_s != IDLE);
    end

    // Converter state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= {SCORE_W{1'b0}};
            bcd_r      <= {BCD_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            last_bin_r <= {SCORE_W{1'b0}};
            ans_r      <= {BCD_W{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            shift_r    <= shift_next_s;
            bcd_r      <= bcd_next_s;
            cnt_r      <= cnt_next_s;
            last_bin_r <= last_bin_next_s;
            ans_r      <= ans_next_s;
            valid_r    <= valid_next_s;
            busy_r     <= busy_next_s;
        end
    end

    assign ans       = ans_r;
    assign ans_valid = valid_r;
    assign busy      = busy_r;

endmodule

// File: rtl/snake_score_bcd.sv
// Apple counter with saturating score, high score and sticky saturation flag;
// the selected value is converted to two BCD digits for the display.
module snake_score_bcd
    import snake_score_pkg::*;
#(
    parameter int SCORE_W   = SCORE_W_DEFAULT,
    parameter int MAX_SCORE = MAX_SCORE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    snake_score_bcd_if.slave  bus
);

    localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

    logic [SCORE_W-1:0] score_r, score_next_s;
    logic [SCORE_W-1:0] hi_r,    hi_next_s;
    logic               sat_r,   sat_next_s;
    logic [SCORE_W-1:0] sel_s;

    // Score update: clear beats increment, increment saturates at MAX_SCORE
    always_comb begin
        score_next_s = score_r;
        sat_next_s   = sat_r;
        if (bus.clr) begin
            score_next_s = {SCORE_W{1'b0}};
            sat_next_s   = 1'b0;
        end else if (bus.inc && (score_r < MAX_V)) begin
            score_next_s = score_r + SCORE_W'(1);
        end else if (bus.inc) begin
            sat_next_s   = 1'b1;
        end else begin
            score_next_s = score_r;
        end
    end

    // High score follows the new score whenever it would be exceeded
    always_comb begin
        if (score_next_s > hi_r) begin
            hi_next_s = score_next_s;
        end else begin
            hi_next_s = hi_r;
        end
    end

    // Display source selection
    always_comb begin
        if (bus.show_hi) begin
            sel_s = hi_r;
        end else begin
            sel_s = score_r;
        end
    end

    // Score, high score and saturation registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_r <= {SCORE_W{1'b0}};
            hi_r    <= {SCORE_W{1'b0}};
            sat_r   <= 1'b0;
        end else begin
            score_r <= score_next_s;
            hi_r    <= hi_next_s;
            sat_r   <= sat_next_s;
        end
    end

    bin2bcd_seq #(
        .SCORE_W (SCORE_W)
    ) u_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin       (sel_s),
        .ans       (bus.ans),
        .ans_valid (bus.ans_valid),
        .busy      (bus.busy)
    );

    assign bus.sat = sat_r;

endmodule

// File: tb/tb_snake_score_bcd.sv
// Randomized self-checking bench for snake_score_bcd against a decimal model.
module tb_snake_score_bcd;

    logic clk;
    logic rst_n;

    snake_score_bcd_if bus ();

    snake_score_bcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int m_score = 0;
    int m_hi    = 0;
    int m_sat   = 0;

    int   vcount  = 0;
    logic [7:0] prev_ans = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    function automatic int model_sel();
        return bus.show_hi ? m_hi : m_score;
    endfunction

    // Count valid pulses; ans may only change together with ans_valid
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ans <= 8'h00;
        end else begin
            if (bus.ans_valid) vcount <= vcount + 1;
            if (bus.ans !== prev_ans) begin
                check_eq("ans_glitch", {31'd0, bus.ans_valid}, 32'd1);
                prev_ans <= bus.ans;
            end
        end
    end

    task automatic tick(input logic i, input logic c);
        bus.inc = i;
        bus.clr = c;
        @(posedge clk);
        #1;
        if (c) begin
            m_score = 0;
            m_sat   = 0;
        end else if (i) begin
            if (m_score < 99) m_score++;
            else m_sat = 1;
        end
        if (m_score > m_hi) m_hi = m_score;
        bus.inc = 1'b0;
        bus.clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_score = 0; m_hi = 0; m_sat = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Two full conversion times are always enough for ans to converge
    task automatic settle_check(input string tag);
        repeat (24) tick(1'b0, 1'b0);
        check_eq({tag, "_ans"}, {24'd0, bus.ans}, to_bcd(model_sel()));
        check_eq({tag, "_sat"}, {31'd0, bus.sat}, m_sat);
        check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int v0;
        int vhits;
        int vpos;
        rst_n       = 1'b0;
        bus.inc     = 1'b0;
        bus.clr     = 1'b0;
        bus.show_hi = 1'b0;

        // reset state and quiet period
        do_reset();
        check_eq("rst_ans", {24'd0, bus.ans}, 32'h00);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_sat", {31'd0, bus.sat}, 32'd0);
        v0 = vcount;
        repeat (20) tick(1'b0, 1'b0);
        check_eq("idle_no_valid", vcount - v0, 32'd0);

        // single inc: one valid pulse in the cycle after the ninth following edge
        tick(1'b1, 1'b0);
        vhits = 0;
        vpos  = -1;
        for (int k = 1; k <= 15; k++) begin
            tick(1'b0, 1'b0);
            if (k == 1) check_eq("busy_rise", {31'd0, bus.busy}, 32'd1);
            if (k == 8) check_eq("ans_not_early", {24'd0, bus.ans}, 32'h00);
            if (bus.ans_valid) begin
                vhits++;
                vpos = k;
                check_eq("single_ans", {24'd0, bus.ans}, 32'h01);
            end
        end
        check_eq("single_valid_cnt", vhits, 32'd1);
        check_eq("single_valid_pos", vpos, 32'd9);

        // spaced incs up to 57
        for (int n = 2; n <= 57; n++) begin
            tick(1'b1, 1'b0);
            repeat (19) tick(1'b0, 1'b0);
            check_eq("spaced_ans", {24'd0, bus.ans}, to_bcd(n));
        end

        // back-to-back incs from 0
        tick(1'b0, 1'b1);
        repeat (12) tick(1'b1, 1'b0);
        settle_check("b2b12");
        check_eq("b2b12_lit", {24'd0, bus.ans}, 32'h12);

        // saturation, clear, high-score display
        tick(1'b0, 1'b1);
        repeat (105) tick(1'b1, 1'b0);
        settle_check("satur");
        check_eq("satur_lit", {24'd0, bus.ans}, 32'h99);
        check_eq("satur_flag", {31'd0, bus.sat}, 32'd1);
        tick(1'b0, 1'b1);
        settle_check("clr");
        check_eq("clr_lit", {24'd0, bus.ans}, 32'h00);
        bus.show_hi = 1'b1;
        settle_check("show_hi");
        check_eq("show_hi_lit", {24'd0, bus.ans}, 32'h99);
        bus.show_hi = 1'b0;

        // clr and inc in the same cycle at 40, hi stays 40
        do_reset();
        repeat (40) tick(1'b1, 1'b0);
        settle_check("at40");
        tick(1'b1, 1'b1);
        settle_check("clr_inc");
        check_eq("clr_inc_lit", {24'd0, bus.ans}, 32'h00);
        bus.show_hi = 1'b1;
        settle_check("hi40");
        check_eq("hi40_lit", {24'd0, bus.ans}, 32'h40);
        bus.show_hi = 1'b0;

        // randomized traffic
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(15, 0) == 0) bus.show_hi = ~bus.show_hi;
            tick(($urandom_range(2, 0) == 0), ($urandom_range(39, 0) == 0));
            if ((it % 60) == 59) settle_check("rand");
        end
        bus.show_hi = 1'b0;

        // reset in the middle of a conversion
        do_reset();
        repeat (30) tick(1'b1, 1'b0);
        settle_check("pre_mid");
        tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        check_eq("mid_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        m_score = 0; m_hi = 0; m_sat = 0;
        #1;
        check_eq("mid_rst_ans", {24'd0, bus.ans}, 32'h00);
        check_eq("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, bus.ans_valid}, 32'd0);
        check_eq("mid_rst_sat", {31'd0, bus.sat}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        v0 = vcount;
        repeat (20) tick(1'b0, 1'b0);
        check_eq("post_rst_valid", vcount - v0, 32'd0);
        check_eq("post_rst_ans", {24'd0, bus.ans}, 32'h00);
        check_eq("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
